gcd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `gcd` core among `NREQ` requesters. It accepts one operand pair at a time and issues it to the core with a one-cycle load pulse. It then waits for completion, guarded by a watchdog, and returns the result on the winning requester's response channel. It sits between the requester ports and a single `gcd` instance, and drives that instance's load and operand inputs.

---
 rtl/gcd_arbiter.sv | 152 +++++++++++++++
 tb/tb_gcd_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one gcd core among NREQ
// requesters. One request is in flight at a time. The request is loaded into
// the core with a single-cycle pulse, and the arbiter then waits for the core
// under a watchdog. The result, or a timeout error, goes back on the winner's
// response channel.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o   per-requester request handshake (ready is one-hot)
//   req_a_i, req_b_i          packed operands, requester k at [k*XLEN +: XLEN]
//   rsp_valid_o/rsp_ready_i   per-requester response handshake (valid is one-hot)
//   rsp_gcd_o, rsp_err_o      result / timeout flag for the flagged requester
//   core_ld_o, core_a_o/b_o   load pulse and latched operands to the core
//   core_ready_i, core_valid_i, core_gcd_i   core status and result
//   busy_o, grant_id_o        not-idle flag, current/last granted requester
module gcd_arbiter #(
  parameter int XLEN    = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ*XLEN-1:0]      req_a_i,
  input  logic [NREQ*XLEN-1:0]      req_b_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [NREQ-1:0]           rsp_valid_o,
  input  logic [NREQ-1:0]           rsp_ready_i,
  output logic [XLEN-1:0]           rsp_gcd_o,
  output logic                      rsp_err_o,
  output logic                      core_ld_o,
  output logic [XLEN-1:0]           core_a_o,
  output logic [XLEN-1:0]           core_b_o,
  input  logic                      core_ready_i,
  input  logic                      core_valid_i,
  input  logic [XLEN-1:0]           core_gcd_i,
  output logic                      busy_o,
  output logic [$clog2(NREQ)-1:0]   grant_id_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } opnd_t;

  state_t                    state_q, state_d;
  opnd_t                     opnd_q;
  logic [IDW-1:0]            ptr_q;
  logic [IDW-1:0]            win_id, cand;
  logic                      win_vld;
  logic [WDW-1:0]            wd_q;
  logic [NREQ-1:0][XLEN-1:0] a_arr, b_arr;
  logic                      accept, core_done, timeout, rsp_hs;

  assign a_arr = req_a_i;
  assign b_arr = req_b_i;

  // Round-robin pick. Scan from the farthest offset down to ptr so that the
  // last hit written, which wins, is the first valid at or after ptr.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (req_valid_i[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Ready is combinational, so it must be masked during reset.
  assign accept    = (state_q == IDLE) && core_ready_i && win_vld && !reset_i;
  // wd_q==0 marks the first WAIT cycle. The core may still be showing the
  // previous done in that cycle.
  assign core_done = core_valid_i && (wd_q != '0);
  assign timeout   = (wd_q == WDW'(TIMEOUT));
  assign rsp_hs    = (state_q == RESP) && rsp_ready_i[grant_id_o];

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done || timeout) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    core_ld_o   = (state_q == ISSUE);
    busy_o      = (state_q != IDLE);
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (accept)            req_ready_o[win_id]     = 1'b1;
    if (state_q == RESP)   rsp_valid_o[grant_id_o] = 1'b1;
  end

  // Datapath: operand latch, grant, watchdog, response, pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      opnd_q     <= '0;
      grant_id_o <= '0;
      ptr_q      <= '0;
      wd_q       <= '0;
      rsp_gcd_o  <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      if (accept) begin
        opnd_q.a   <= a_arr[win_id];
        opnd_q.b   <= b_arr[win_id];
        grant_id_o <= win_id;
      end
      // Saturating watchdog. WAIT is left as soon as it hits TIMEOUT.
      if (state_q == ISSUE)
        wd_q <= '0;
      else if (state_q == WAIT && !timeout)
        wd_q <= wd_q + 1'b1;
      // A valid result takes priority over a timeout in the same cycle.
      if (state_q == WAIT) begin
        if (core_done) begin
          rsp_gcd_o <= core_gcd_i;
          rsp_err_o <= 1'b0;
        end else if (timeout) begin
          rsp_gcd_o <= '0;
          rsp_err_o <= 1'b1;
        end
      end
      if (rsp_hs)
        ptr_q <= (grant_id_o == IDW'(NREQ-1)) ? '0 : grant_id_o + 1'b1;
    end
  end

  assign core_a_o = opnd_q.a;
  assign core_b_o = opnd_q.b;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter. A behavioural gcd core stub sits behind the
// arbiter. It has programmable latency and keeps its previous done flag for
// one cycle after a load. It can also be made to never respond. Expected
// responses go into a queue when requests are posted and are popped when a
// response handshake happens.
module tb_gcd_arbiter;
  localparam int XLEN    = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [1:0]      id;
    logic [XLEN-1:0] g;
    logic            err;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset_i;
  logic [NREQ-1:0]           req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NREQ-1:0][XLEN-1:0] req_a, req_b;
  logic [XLEN-1:0]           rsp_gcd_o, core_a_o, core_b_o;
  logic                      rsp_err_o, core_ld_o, busy_o;
  logic [1:0]                grant_id_o;
  logic                      core_ready, core_valid;
  logic [XLEN-1:0]           core_gcd;

  exp_t            sb[$];
  exp_t            e;
  int              total = 0;
  int              passed = 0;
  int              n;
  logic            found;
  logic [NREQ-1:0] oh;
  logic [NREQ-1:0] hs_req = '0;

  always #5 clk = ~clk;

  gcd_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_gcd_o(rsp_gcd_o), .rsp_err_o(rsp_err_o),
    .core_ld_o(core_ld_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_ready_i(core_ready), .core_valid_i(core_valid), .core_gcd_i(core_gcd),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  function automatic logic [XLEN-1:0] ref_gcd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core stub. The result is published only when the core completes, so a
  // stale done still shows the old result.
  logic            core_busy, core_stale;
  logic            core_dead = 1'b0;
  int              core_lat = 2;
  int              core_cnt;
  logic [XLEN-1:0] core_nxt;

  always @(posedge clk) begin
    if (reset_i) begin
      core_busy <= 1'b0; core_stale <= 1'b0; core_valid <= 1'b0;
      core_cnt <= 0; core_gcd <= '0; core_nxt <= '0;
    end else if (core_ld_o) begin
      core_busy <= 1'b1; core_stale <= 1'b1; core_cnt <= core_lat;
      core_nxt <= ref_gcd(core_a_o, core_b_o);
    end else begin
      core_stale <= 1'b0;
      if (core_stale) core_valid <= 1'b0;
      if (core_busy) begin
        if (core_cnt == 0) begin
          core_busy <= 1'b0;
          core_gcd  <= core_nxt;
          if (!core_dead) core_valid <= 1'b1;
        end else core_cnt <= core_cnt - 1;
      end
    end
  end
  assign core_ready = !core_busy;

  // Requests accepted at the last edge are withdrawn by step() unless hold=1.
  logic hold = 1'b0;
  always @(posedge clk) hs_req <= reset_i ? '0 : (req_valid_i & req_ready_o);

  task automatic step();
    @(negedge clk);
    if (!hold) req_valid_i = req_valid_i & ~hs_req;
  endtask

  task automatic post(input logic [1:0] k, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_a[k] = a;
    req_b[k] = b;
    req_valid_i[k] = 1'b1;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req_valid_i = '1;
    step(); step(); #1;
    total++; if (req_ready_o !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); else passed++;
    total++; if (rsp_valid_o !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); else passed++;
    total++; if ({busy_o, core_ld_o, rsp_err_o} !== 3'b000) $display("FAIL reset_flags: got busy/ld/err %b want 000", {busy_o, core_ld_o, rsp_err_o}); else passed++;
    total++; if (grant_id_o !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id_o); else passed++;
    total++; if (rsp_gcd_o !== 0 || core_a_o !== 0 || core_b_o !== 0) $display("FAIL reset_data: got gcd=%0h a=%0h b=%0h want 0", rsp_gcd_o, core_a_o, core_b_o); else passed++;
    reset_i = 1'b0;
    req_valid_i = '0;
    step(); #1;
    total++; if (busy_o !== 1'b0 || req_ready_o !== 4'b0000) $display("FAIL reset_idle: got busy=%b rdy=%b want 0 0000", busy_o, req_ready_o); else passed++;
  endtask

  task automatic test_single();
    step(); post(2'd1, 48, 18); #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL single_accept: got %b want 0010", req_ready_o); else passed++;
    sb.push_back(exp_t'{2'd1, 32'd6, 1'b0});
    step(); #1;
    total++; if (core_ld_o !== 1'b1 || core_a_o !== 48 || core_b_o !== 18) $display("FAIL single_issue: got ld=%b a=%0d b=%0d want 1 48 18", core_ld_o, core_a_o, core_b_o); else passed++;
    total++; if (grant_id_o !== 2'd1 || busy_o !== 1'b1) $display("FAIL single_grant: got id=%0d busy=%b want 1 1", grant_id_o, busy_o); else passed++;
    step(); #1;
    total++; if (core_ld_o !== 1'b0) $display("FAIL single_ld_pulse: got %b want 0", core_ld_o); else passed++;
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL single_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
        else passed++;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL single_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_two_simul();
    pulse_reset();
    step(); post(2'd0, 35, 14); post(2'd2, 81, 27); #1;
    total++; if (req_ready_o !== 4'b0001) $display("FAIL two_first: got %b want 0001", req_ready_o); else passed++;
    sb.push_back(exp_t'{2'd0, 32'd7, 1'b0});
    sb.push_back(exp_t'{2'd2, 32'd27, 1'b0});
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL two_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
        else passed++;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL two_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
    // ptr is now 3: requester 3 must beat requester 0.
    step(); post(2'd0, 16, 12); post(2'd3, 50, 20); #1;
    total++; if (req_ready_o !== 4'b1000) $display("FAIL two_ptr3: got %b want 1000", req_ready_o); else passed++;
    sb.push_back(exp_t'{2'd3, 32'd10, 1'b0});
    sb.push_back(exp_t'{2'd0, 32'd4, 1'b0});
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL ptr3_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
        else passed++;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL ptr3_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_round_robin();
    pulse_reset();
    step();
    hold = 1'b1;
    for (int k = 0; k < NREQ; k++) post(2'(k), 32'((k + 1) * 12), 32'((k + 1) * 8));
    for (int r = 0; r < 6; r++) sb.push_back(exp_t'{2'(r % NREQ), 32'(((r % NREQ) + 1) * 4), 1'b0});
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || grant_id_o !== e.id || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL rr_order: got v=%b id=%0d g=%0d want v=%b id=%0d g=%0d", rsp_valid_o, grant_id_o, rsp_gcd_o, oh, e.id, e.g);
        else passed++;
        if (sb.size() == 0) req_valid_i = '0;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL rr_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
    hold = 1'b0;
  endtask

  task automatic test_backpressure();
    step(); post(2'd0, 12, 8);
    rsp_ready_i = 4'b1110;
    sb.push_back(exp_t'{2'd0, 32'd4, 1'b0});
    for (int c = 0; c < 40 && rsp_valid_o == '0; c++) begin step(); #1; end
    post(2'd1, 100, 75);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      total++;
      if (rsp_valid_o !== 4'b0001 || rsp_gcd_o !== 32'd4 || req_ready_o !== 4'b0000)
        $display("FAIL bp_hold%0d: got v=%b g=%0d rdy=%b want v=0001 g=4 rdy=0000", i, rsp_valid_o, rsp_gcd_o, req_ready_o);
      else passed++;
    end
    rsp_ready_i = 4'b1111; #1;
    e = sb.pop_front();
    total++;
    if (rsp_valid_o !== 4'b0001 || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
      $display("FAIL bp_release: got v=%b g=%0d e=%b want v=0001 g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, e.g, e.err);
    else passed++;
    step(); #1;
    total++; if (busy_o !== 1'b0 || req_ready_o !== 4'b0010) $display("FAIL bp_idle: got busy=%b rdy=%b want 0 0010", busy_o, req_ready_o); else passed++;
    sb.push_back(exp_t'{2'd1, 32'd25, 1'b0});
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL bp_next_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
        else passed++;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL bp_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_timeout();
    core_dead = 1'b1;
    step(); post(2'd3, 9, 6);
    sb.push_back(exp_t'{2'd3, 32'd0, 1'b1});
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin step(); #1; found = core_ld_o; end
    n = 0;
    while (n < 60 && rsp_valid_o == '0) begin step(); #1; n++; end
    total++; if (n != TIMEOUT + 2) $display("FAIL to_latency: got %0d cycles from load want %0d", n, TIMEOUT + 2); else passed++;
    e = sb.pop_front(); oh = 4'b0001 << e.id;
    total++;
    if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
      $display("FAIL to_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
    else passed++;
    core_dead = 1'b0;
  endtask

  // Core done landing on the last watchdog cycle (lat 15) must win. One cycle
  // later (lat 16) is a timeout.
  task automatic test_tie();
    for (int j = 0; j < 2; j++) begin
      core_lat = 15 + j;
      step(); post(2'(j), 21, 14);
      sb.push_back(exp_t'{2'(j), (j == 0) ? 32'd7 : 32'd0, 1'(j)});
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin step(); #1; found = core_ld_o; end
      n = 0;
      while (n < 60 && rsp_valid_o == '0) begin step(); #1; n++; end
      total++; if (n != TIMEOUT + 2) $display("FAIL tie%0d_latency: got %0d want %0d", j, n, TIMEOUT + 2); else passed++;
      e = sb.pop_front(); oh = 4'b0001 << e.id;
      total++;
      if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
        $display("FAIL tie%0d_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", j, rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
      else passed++;
    end
    core_lat = 2;
    // Zero operand passes straight through to the core.
    step(); post(2'd2, 0, 5);
    sb.push_back(exp_t'{2'd2, 32'd5, 1'b0});
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL zero_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
        else passed++;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL zero_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_reset_mid_wait();
    step(); post(2'd2, 30, 12);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin step(); #1; found = core_ld_o; end
    repeat (3) step();
    reset_i = 1'b1;
    req_valid_i = '1;
    step(); #1;
    total++;
    if ({busy_o, core_ld_o, rsp_err_o} !== 3'b000 || rsp_valid_o !== 4'b0000 || req_ready_o !== 4'b0000)
      $display("FAIL mid_reset_ctl: got busy=%b ld=%b err=%b v=%b rdy=%b want all 0", busy_o, core_ld_o, rsp_err_o, rsp_valid_o, req_ready_o);
    else passed++;
    total++; if (grant_id_o !== 2'd0 || rsp_gcd_o !== 0 || core_a_o !== 0 || core_b_o !== 0)
      $display("FAIL mid_reset_data: got id=%0d g=%0d a=%0d b=%0d want 0", grant_id_o, rsp_gcd_o, core_a_o, core_b_o);
    else passed++;
    reset_i = 1'b0;
    req_valid_i = '0;
    n = 0;
    for (int c = 0; c < 20; c++) begin step(); #1; if (rsp_valid_o != '0 || busy_o) n++; end
    total++; if (n != 0) $display("FAIL mid_reset_dropped: got %0d busy/response cycles want 0", n); else passed++;
    post(2'd1, 45, 30); post(2'd3, 64, 48); #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL mid_reset_ptr0: got %b want 0010", req_ready_o); else passed++;
    sb.push_back(exp_t'{2'd1, 32'd15, 1'b0});
    sb.push_back(exp_t'{2'd3, 32'd16, 1'b0});
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      step(); #1;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front(); oh = 4'b0001 << e.id;
        total++;
        if (rsp_valid_o !== oh || rsp_gcd_o !== e.g || rsp_err_o !== e.err)
          $display("FAIL mid_reset_rsp: got v=%b g=%0d e=%b want v=%b g=%0d e=%b", rsp_valid_o, rsp_gcd_o, rsp_err_o, oh, e.g, e.err);
        else passed++;
      end
    end
    total++; if (sb.size() != 0) begin $display("FAIL mid_reset_drain: got %0d outstanding want 0", sb.size()); sb.delete(); end else passed++;
  endtask

  initial begin
    reset_i     = 1'b1;
    req_valid_i = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready_i = '1;
    test_reset();
    test_single();
    test_two_simul();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_tie();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
